// File: rtl/alu_imm_sequencer_if.sv
// Control bundle between the register-immediate sequencer and the datapath:
// instruction inputs plus every control line, status flag and counter.
interface alu_imm_sequencer_if #(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 5,
    parameter int CNT_W    = 16
);
    logic                start;
    logic                mem_ready;
    logic [OPCODE_W-1:0] ir_opcode;

    logic PCout, IncPC, MARin;
    logic read, RAMenable, MDRin;
    logic MDRout, IRin;
    logic Grb, Rout, Yin;
    logic Cout;
    logic ZMuxEnable, ZMuxOut, Gra, Rin;
    logic ZSelect;

    logic [ALU_OP_W-1:0] aluControl;
    logic                busy;
    logic                done;
    logic                illegal;
    logic                fault;
    logic [CNT_W-1:0]    instr_count;

    // Sequencer side
    modport master (
        input  start, mem_ready, ir_opcode,
        output PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
               Grb, Rout, Yin, Cout, ZMuxEnable, ZMuxOut, Gra, Rin, ZSelect,
               aluControl, busy, done, illegal, fault, instr_count
    );

    // Datapath / instruction-register side
    modport slave (
        output start, mem_ready, ir_opcode,
        input  PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
               Grb, Rout, Yin, Cout, ZMuxEnable, ZMuxOut, Gra, Rin, ZSelect,
               aluControl, busy, done, illegal, fault, instr_count
    );
endinterface

// File: rtl/alu_imm_sequencer.sv
// T0..T5 control-step sequencer for addi/andi/ori with memory wait, opcode decode,
// illegal detection and retire counter. Define ALU_IMM_SEQ_TIMEOUT_EN for the T1 timeout.
module alu_imm_sequencer #(
    parameter int OPCODE_W     = 5,
    parameter int ALU_OP_W     = 5,
    parameter int CNT_W        = 16,
    parameter int AUTO_RESTART = 0,
    parameter int MEM_TIMEOUT  = 8
) (
    input logic             clock,
    input logic             clear,
    alu_imm_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
    } state_t;

    typedef struct packed {
        logic pc_out, inc_pc, mar_in;
        logic read, ram_en, mdr_in;
        logic mdr_out, ir_in;
        logic grb, r_out, y_in;
        logic c_out;
        logic zmux_en, zmux_out, gra, r_in;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(5'b01100);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(5'b01101);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(5'b01110);
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(5'b00011);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(5'b00101);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(5'b00110);

    state_t              state_q, state_d;
    ctrl_t               ctrl_q;
    logic [ALU_OP_W-1:0] alu_q, alu_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

`ifdef ALU_IMM_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic              fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // Control lines are a pure function of the step; Rin only ever appears in T5.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_T0: begin c.pc_out = 1'b1; c.inc_pc = 1'b1; c.mar_in = 1'b1; end
            S_T1: begin c.read = 1'b1; c.ram_en = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            S_T4: c.c_out = 1'b1;
            S_T5: begin c.zmux_en = 1'b1; c.zmux_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
        fault_d   = fault_q;
        wait_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_T0;
                    illegal_d = 1'b0;
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
                    fault_d   = 1'b0;
`endif
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
                // wait_q counts completed T1 cycles; the last allowed one gives up.
                else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                state_d = S_T4;
                case (bus.ir_opcode)
                    OP_ADDI: alu_d = ALU_ADD;
                    OP_ANDI: alu_d = ALU_AND;
                    OP_ORI:  alu_d = ALU_OR;
                    default: begin
                        state_d   = S_IDLE;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                state_d = (AUTO_RESTART != 0) ? S_T0 : S_IDLE;
                cnt_d   = cnt_q + CNT_W'(1);
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            alu_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
            fault_q   <= 1'b0;
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode_ctrl(state_d);
            alu_q     <= alu_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
            fault_q   <= fault_d;
            wait_q    <= wait_d;
`endif
        end
    end

    assign bus.PCout       = ctrl_q.pc_out;
    assign bus.IncPC       = ctrl_q.inc_pc;
    assign bus.MARin       = ctrl_q.mar_in;
    assign bus.read        = ctrl_q.read;
    assign bus.RAMenable   = ctrl_q.ram_en;
    assign bus.MDRin       = ctrl_q.mdr_in;
    assign bus.MDRout      = ctrl_q.mdr_out;
    assign bus.IRin        = ctrl_q.ir_in;
    assign bus.Grb         = ctrl_q.grb;
    assign bus.Rout        = ctrl_q.r_out;
    assign bus.Yin         = ctrl_q.y_in;
    assign bus.Cout        = ctrl_q.c_out;
    assign bus.ZMuxEnable  = ctrl_q.zmux_en;
    assign bus.ZMuxOut     = ctrl_q.zmux_out;
    assign bus.Gra         = ctrl_q.gra;
    assign bus.Rin         = ctrl_q.r_in;
    assign bus.ZSelect     = 1'b0;
    assign bus.aluControl  = alu_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = cnt_q;
`ifdef ALU_IMM_SEQ_TIMEOUT_EN
    assign bus.fault       = fault_q;
`else
    assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_imm_sequencer.sv
// Bench for alu_imm_sequencer: vector table, random instruction stream against a
// step-list model, and hand sequences for clear, timeout and back-to-back restart.
module tb_alu_imm_sequencer;

    localparam int PH_IDLE = 7;

    logic clock;
    logic clear, clear2;
    int   tests = 0;
    int   fails = 0;

    logic [4:0] m_alu;
    logic [3:0] m_cnt;
    logic       m_ill;

    alu_imm_sequencer_if #(.CNT_W(4)) bus ();
    alu_imm_sequencer_if #(.CNT_W(4)) bus2 ();

    alu_imm_sequencer #(.CNT_W(4)) dut (
        .clock(clock), .clear(clear), .bus(bus)
    );
    alu_imm_sequencer #(.CNT_W(4), .AUTO_RESTART(1)) dut2 (
        .clock(clock), .clear(clear2), .bus(bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] op;
        int         w;
        logic       legal;
        logic [4:0] alu;
    } vec_t;

    // Control lines in order PCout..Rin, as the step table lists them.
    function automatic logic [15:0] exp_ctrl(input int ph);
        case (ph)
            0: return 16'b1110_0000_0000_0000;
            1: return 16'b0001_1100_0000_0000;
            2: return 16'b0000_0011_0000_0000;
            3: return 16'b0000_0000_1110_0000;
            4: return 16'b0000_0000_0001_0000;
            5: return 16'b0000_0000_0000_1111;
            default: return 16'b0;
        endcase
    endfunction

    function automatic logic [5:0] model_decode(input logic [4:0] op);
        case (op)
            5'b01100: return {1'b1, 5'b00011};
            5'b01101: return {1'b1, 5'b00101};
            5'b01110: return {1'b1, 5'b00110};
            default:  return {1'b0, 5'b00000};
        endcase
    endfunction

    function automatic logic [29:0] obs1();
        return {bus.PCout, bus.IncPC, bus.MARin, bus.read, bus.RAMenable, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Grb, bus.Rout, bus.Yin, bus.Cout,
                bus.ZMuxEnable, bus.ZMuxOut, bus.Gra, bus.Rin, bus.ZSelect,
                bus.busy, bus.done, bus.illegal, bus.fault, bus.aluControl, bus.instr_count};
    endfunction

    function automatic logic [17:0] obs2();
        return {bus2.PCout, bus2.IncPC, bus2.MARin, bus2.read, bus2.RAMenable, bus2.MDRin,
                bus2.MDRout, bus2.IRin, bus2.Grb, bus2.Rout, bus2.Yin, bus2.Cout,
                bus2.ZMuxEnable, bus2.ZMuxOut, bus2.Gra, bus2.Rin, bus2.busy, bus2.done};
    endfunction

    function automatic logic [29:0] mk(input int ph, input logic dn, input logic il,
                                       input logic flt, input logic [4:0] a, input logic [3:0] c);
        return {exp_ctrl(ph), 1'b0, (ph != PH_IDLE), dn, il, flt, a, c};
    endfunction

    task automatic check(input string nm, input logic [29:0] act, input logic [29:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in an IDLE cycle; leaves in the IDLE cycle after the instruction ends.
    task automatic run_instr(input string nm, input logic [4:0] op, input int w,
                             input logic legal, input logic [4:0] alu_exp);
        int ph[$];
        int t1i;
        ph.push_back(0);
        repeat (w + 1) ph.push_back(1);
        ph.push_back(2);
        ph.push_back(3);
        if (legal) begin
            ph.push_back(4);
            ph.push_back(5);
        end
        t1i = 0;
        bus.start     = 1'b1;
        bus.mem_ready = 1'($urandom);
        bus.ir_opcode = 5'($urandom);
        for (int i = 0; i < ph.size(); i++) begin
            tick();
            check($sformatf("%s step%0d", nm, i), obs1(),
                  mk(ph[i], 1'b0, 1'b0, 1'b0, (ph[i] >= 4) ? alu_exp : m_alu, m_cnt));
            bus.start = 1'($urandom);
            if (ph[i] == 1) begin
                bus.mem_ready = (t1i == w);
                t1i++;
            end else begin
                bus.mem_ready = 1'($urandom);
            end
            bus.ir_opcode = (ph[i] >= 2) ? op : 5'($urandom);
        end
        tick();
        bus.start = 1'b0;
        if (legal) begin
            m_alu = alu_exp;
            m_cnt = m_cnt + 4'd1;
        end
        m_ill = !legal;
        check({nm, " end"}, obs1(), mk(PH_IDLE, legal, m_ill, 1'b0, m_alu, m_cnt));
    endtask

    initial begin
        vec_t tbl[6];
        logic [5:0] dec;
        logic [4:0] op;
        int rins;

        tbl[0] = '{5'b01101, 0, 1'b1, 5'b00101};
        tbl[1] = '{5'b01100, 3, 1'b1, 5'b00011};
        tbl[2] = '{5'b00010, 0, 1'b0, 5'b00000};
        tbl[3] = '{5'b01110, 1, 1'b1, 5'b00110};
        tbl[4] = '{5'b11111, 2, 1'b0, 5'b00000};
        tbl[5] = '{5'b01100, 7, 1'b1, 5'b00011};

        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.ir_opcode = '0;
        bus2.start = 1'b0; bus2.mem_ready = 1'b0; bus2.ir_opcode = '0;
        m_alu = '0; m_cnt = '0; m_ill = 1'b0;

        clear = 1'b1; clear2 = 1'b1;
        tick(); tick();
        clear = 1'b0; clear2 = 1'b0;
        tick();
        check("reset", obs1(), mk(PH_IDLE, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0));
        check("reset2", {12'b0, obs2()}, 30'b0);

        for (int i = 0; i < 6; i++) begin
            // The stored alu for an illegal vector must be the retained value.
            run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].w, tbl[i].legal,
                      tbl[i].legal ? tbl[i].alu : m_alu);
        end

        // clear mid-instruction aborts and zeroes everything
        bus.start = 1'b1; bus.mem_ready = 1'b0;
        tick(); bus.start = 1'b0;
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_alu = '0; m_cnt = '0; m_ill = 1'b0;
        check("clear_mid", obs1(), mk(PH_IDLE, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0));

        // clear and start on the same edge
        run_instr("pre_cs", 5'b01101, 0, 1'b1, 5'b00101);
        bus.start = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; bus.start = 1'b0;
        m_alu = '0; m_cnt = '0; m_ill = 1'b0;
        check("clear_wins", obs1(), mk(PH_IDLE, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0));
        tick();
        check("clear_wins_idle", obs1(), mk(PH_IDLE, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0));

`ifdef ALU_IMM_SEQ_TIMEOUT_EN
        bus.start = 1'b1; bus.mem_ready = 1'b0;
        tick(); bus.start = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        check("timeout_last_t1", obs1(), mk(1, 1'b0, 1'b0, 1'b0, m_alu, m_cnt));
        tick();
        m_ill = 1'b0;
        check("timeout_fault", obs1(), mk(PH_IDLE, 1'b0, 1'b0, 1'b1, m_alu, m_cnt));
`endif

        // random stream; 4-bit counter wraps along the way
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 4) < 3) ? 5'(5'd12 + 5'($urandom_range(0, 2))) : 5'($urandom);
            dec = model_decode(op);
            run_instr($sformatf("rnd%0d", n), op, $urandom_range(0, 7), dec[5],
                      dec[5] ? dec[4:0] : m_alu);
        end

        // back-to-back restart, then clear in T3 of the fourth instruction
        bus2.start = 1'b1; bus2.mem_ready = 1'b1; bus2.ir_opcode = 5'b01110;
        rins = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus2.start = 1'b0;
            if (bus2.Rin) rins++;
            check($sformatf("auto c%0d", c), {12'b0, obs2()},
                  {12'b0, exp_ctrl((c - 1) % 6), 1'b1, (c == 7 || c == 13 || c == 19)});
            if (c == 19)
                check("auto cnt3", {21'b0, bus2.aluControl, bus2.instr_count},
                      {21'b0, 5'b00110, 4'd3});
            if (c == 22) clear2 = 1'b1;
        end
        tick();
        clear2 = 1'b0;
        if (bus2.Rin) rins++;
        check("auto clear", {12'b0, obs2()}, 30'b0);
        check("auto rin count", 30'(rins), 30'd3);
        check("auto cnt clr", {26'b0, bus2.instr_count}, 30'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
